// File: rtl/regfile_tagged.sv
// rtl/regfile_tagged.sv - Architectural register file with per-register rename status (busy + producer tag)
// Commit, rename and flush update state on the rising edge; read ports are combinational with commit bypass.
module regfile_tagged #(
    parameter  int XLEN  = 32,
    parameter  int NREG  = 32,
    parameter  int NRD   = 2,
    parameter  int TAG_W = 4,
    localparam int AW    = $clog2(NREG)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 we,
    input  logic [AW-1:0]        waddr,
    input  logic [XLEN-1:0]      wdata,
    input  logic [TAG_W-1:0]     wtag,
    input  logic                 ren_en,
    input  logic [AW-1:0]        ren_addr,
    input  logic [TAG_W-1:0]     ren_tag,
    input  logic                 flush,
    input  logic [NRD-1:0]       re,
    input  logic [NRD*AW-1:0]    raddr,
    output logic [NRD*XLEN-1:0]  rdata,
    output logic [NRD-1:0]       rbusy,
    output logic [NRD*TAG_W-1:0] rtag,
    output logic [AW:0]          busy_cnt
);
    localparam int NSLOT = 1 << AW;

    // One bit per encodable address: set only for real, writable registers (excludes x0 and >= NREG).
    function automatic logic [NSLOT-1:0] live_mask();
        logic [NSLOT-1:0] m;
        for (int i = 0; i < NSLOT; i++) begin
            m[i] = (i != 0) && (i < NREG);
        end
        return m;
    endfunction
    localparam logic [NSLOT-1:0] LIVE = live_mask();

    logic [XLEN-1:0]  regs_q [NREG];
    logic [XLEN-1:0]  regs_d [NREG];
    logic [TAG_W-1:0] tag_q  [NREG];
    logic [TAG_W-1:0] tag_d  [NREG];
    logic [NREG-1:0]  busy_q;
    logic [NREG-1:0]  busy_d;
    logic [AW:0]      busy_cnt_q;
    logic [AW:0]      busy_cnt_d;
    logic             commit_ok;
    logic             rename_ok;

    assign commit_ok = we && LIVE[waddr];
    assign rename_ok = ren_en && LIVE[ren_addr] && !flush;

    // Rename is applied after commit so a same-cycle rename of the committing register keeps it busy.
    always_comb begin
        regs_d = regs_q;
        tag_d  = tag_q;
        busy_d = busy_q;
        if (commit_ok) begin
            regs_d[waddr] = wdata;
            if (busy_q[waddr] && (tag_q[waddr] == wtag)) begin
                busy_d[waddr] = 1'b0;
            end
        end
        if (rename_ok) begin
            busy_d[ren_addr] = 1'b1;
            tag_d[ren_addr]  = ren_tag;
        end
        if (flush) begin
            busy_d = '0;
        end
    end

    always_comb begin
        busy_cnt_d = '0;
        for (int i = 0; i < NREG; i++) begin
            busy_cnt_d = busy_cnt_d + (AW+1)'(busy_d[i]);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) begin
                regs_q[i] <= '0;
                tag_q[i]  <= '0;
            end
            busy_q     <= '0;
            busy_cnt_q <= '0;
        end else begin
            regs_q     <= regs_d;
            tag_q      <= tag_d;
            busy_q     <= busy_d;
            busy_cnt_q <= busy_cnt_d;
        end
    end

    assign busy_cnt = busy_cnt_q;

    for (genvar g = 0; g < NRD; g++) begin : g_rd
        logic [AW-1:0] ra;
        logic          hit;
        logic          bypass;

        assign ra     = raddr[g*AW +: AW];
        assign hit    = !rst && re[g] && LIVE[ra];
        assign bypass = we && (waddr == ra);

        // Bypass reports the post-commit busy state: a matching tag retires the producer this cycle.
        assign rdata[g*XLEN +: XLEN]  = !hit ? '0 : (bypass ? wdata : regs_q[ra]);
        assign rbusy[g]               = hit && busy_q[ra] && !(bypass && (tag_q[ra] == wtag));
        assign rtag[g*TAG_W +: TAG_W] = hit ? tag_q[ra] : '0;
    end

endmodule

// File: tb/tb_regfile_tagged.sv
// tb/tb_regfile_tagged.sv - Self-checking bench for regfile_tagged
// Directed rename/commit/flush scenarios plus randomized traffic against an array-based model.
module tb_regfile_tagged;
    localparam int XLEN  = 32;
    localparam int NREG  = 32;
    localparam int NRD   = 2;
    localparam int TAG_W = 4;
    localparam int AW    = 5;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 we;
    logic [AW-1:0]        waddr;
    logic [XLEN-1:0]      wdata;
    logic [TAG_W-1:0]     wtag;
    logic                 ren_en;
    logic [AW-1:0]        ren_addr;
    logic [TAG_W-1:0]     ren_tag;
    logic                 flush;
    logic [NRD-1:0]       re;
    logic [NRD*AW-1:0]    raddr;
    logic [NRD*XLEN-1:0]  rdata;
    logic [NRD-1:0]       rbusy;
    logic [NRD*TAG_W-1:0] rtag;
    logic [AW:0]          busy_cnt;

    always #5 clk = ~clk;

    regfile_tagged #(.XLEN(XLEN), .NREG(NREG), .NRD(NRD), .TAG_W(TAG_W)) dut (
        .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata), .wtag(wtag),
        .ren_en(ren_en), .ren_addr(ren_addr), .ren_tag(ren_tag), .flush(flush),
        .re(re), .raddr(raddr), .rdata(rdata), .rbusy(rbusy), .rtag(rtag), .busy_cnt(busy_cnt)
    );

    logic [XLEN-1:0]  m_regs [NREG];
    logic             m_busy [NREG];
    logic [TAG_W-1:0] m_tag  [NREG];
    int checks   = 0;
    int failures = 0;

    function automatic int m_count();
        int n = 0;
        for (int i = 0; i < NREG; i++) n += int'(m_busy[i]);
        return n;
    endfunction

    task automatic m_reset();
        for (int i = 0; i < NREG; i++) begin
            m_regs[i] = '0;
            m_busy[i] = 1'b0;
            m_tag[i]  = '0;
        end
    endtask

    function automatic void m_read(input logic en, input logic [AW-1:0] a,
                                   output logic [XLEN-1:0] d, output logic b, output logic [TAG_W-1:0] t);
        d = '0; b = 1'b0; t = '0;
        if (rst || !en || a == 0) return;
        t = m_tag[a];
        if (we && waddr == a) begin
            d = wdata;
            b = m_busy[a] && (m_tag[a] != wtag);
        end else begin
            d = m_regs[a];
            b = m_busy[a];
        end
    endfunction

    task automatic idle();
        we = 1'b0; waddr = '0; wdata = '0; wtag = '0;
        ren_en = 1'b0; ren_addr = '0; ren_tag = '0;
        flush = 1'b0; re = '0; raddr = '0;
    endtask

    task automatic rd(input int p, input logic [AW-1:0] a);
        re[p] = 1'b1;
        raddr[p*AW +: AW] = a;
    endtask

    // Apply the architectural rules to the model, then clock the DUT.
    task automatic tick();
        logic [XLEN-1:0]  nr [NREG];
        logic             nb [NREG];
        logic [TAG_W-1:0] nt [NREG];
        nr = m_regs; nb = m_busy; nt = m_tag;
        if (we && waddr != 0) begin
            nr[waddr] = wdata;
            if (m_busy[waddr] && m_tag[waddr] == wtag) nb[waddr] = 1'b0;
        end
        if (flush) begin
            for (int i = 0; i < NREG; i++) nb[i] = 1'b0;
        end else if (ren_en && ren_addr != 0) begin
            nb[ren_addr] = 1'b1;
            nt[ren_addr] = ren_tag;
        end
        @(posedge clk);
        #1;
        m_regs = nr; m_busy = nb; m_tag = nt;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle();
        m_reset();
        rd(0, 5'd3); rd(1, 5'd17);
        #12;
        checks++; if (busy_cnt !== '0) begin failures++; $display("FAIL reset_busy_cnt got=%0d exp=0", busy_cnt); end
        checks++; if (rdata !== '0) begin failures++; $display("FAIL reset_rdata got=%h exp=0", rdata); end
        checks++; if (rbusy !== '0 || rtag !== '0) begin failures++; $display("FAIL reset_rbusy_rtag got=%b/%h exp=0/0", rbusy, rtag); end
        rst = 1'b0;
        idle();
        tick();
        // Asynchronous reset in the middle of a cycle
        ren_en = 1'b1; ren_addr = 5'd5; ren_tag = 4'd3;
        tick();
        idle(); rd(0, 5'd5);
        #1;
        checks++; if (rbusy[0] !== 1'b1 || busy_cnt !== 6'd1) begin failures++; $display("FAIL t1_pre_rst got=%b/%0d exp=1/1", rbusy[0], busy_cnt); end
        #1 rst = 1'b1;
        m_reset();
        #1;
        checks++; if (rbusy !== '0 || rdata !== '0 || busy_cnt !== '0) begin failures++; $display("FAIL t1_async_rst got=%b/%h/%0d exp=0/0/0", rbusy, rdata, busy_cnt); end
        #1 rst = 1'b0;
        idle();
        tick();
    endtask

    task automatic test_rename_commit();
        idle(); ren_en = 1'b1; ren_addr = 5'd5; ren_tag = 4'd3;
        tick();
        idle(); rd(0, 5'd5);
        #1;
        checks++; if (rbusy[0] !== 1'b1 || rtag[0 +: TAG_W] !== 4'd3 || busy_cnt !== 6'd1) begin
            failures++; $display("FAIL t2_renamed got=%b/%0d/%0d exp=1/3/1", rbusy[0], rtag[0 +: TAG_W], busy_cnt); end
        we = 1'b1; waddr = 5'd5; wdata = 32'hDEAD; wtag = 4'd3;
        #1;
        checks++; if (rdata[0 +: XLEN] !== 32'hDEAD || rbusy[0] !== 1'b0) begin
            failures++; $display("FAIL t2_bypass got=%h/%b exp=0000dead/0", rdata[0 +: XLEN], rbusy[0]); end
        tick();
        idle();
        checks++; if (busy_cnt !== 6'd0) begin failures++; $display("FAIL t2_cnt_after got=%0d exp=0", busy_cnt); end
    endtask

    task automatic test_stale_commit();
        idle(); ren_en = 1'b1; ren_addr = 5'd7; ren_tag = 4'd1;
        tick();
        ren_tag = 4'd2;
        tick();
        idle(); we = 1'b1; waddr = 5'd7; wdata = 32'h11; wtag = 4'd1; rd(1, 5'd7);
        #1;
        checks++; if (rdata[XLEN +: XLEN] !== 32'h11 || rbusy[1] !== 1'b1 || rtag[TAG_W +: TAG_W] !== 4'd2) begin
            failures++; $display("FAIL t3_stale_bypass got=%h/%b/%0d exp=11/1/2", rdata[XLEN +: XLEN], rbusy[1], rtag[TAG_W +: TAG_W]); end
        tick();
        idle(); rd(1, 5'd7);
        #1;
        checks++; if (rdata[XLEN +: XLEN] !== 32'h11 || rbusy[1] !== 1'b1 || rtag[TAG_W +: TAG_W] !== 4'd2) begin
            failures++; $display("FAIL t3_stale_after got=%h/%b/%0d exp=11/1/2", rdata[XLEN +: XLEN], rbusy[1], rtag[TAG_W +: TAG_W]); end
    endtask

    task automatic test_commit_rename_same_cycle();
        idle(); ren_en = 1'b1; ren_addr = 5'd9; ren_tag = 4'd4;
        tick();
        idle(); we = 1'b1; waddr = 5'd9; wdata = 32'h9999_0009; wtag = 4'd4;
        ren_en = 1'b1; ren_addr = 5'd9; ren_tag = 4'd6;
        tick();
        idle(); rd(0, 5'd9);
        #1;
        checks++; if (rbusy[0] !== 1'b1 || rtag[0 +: TAG_W] !== 4'd6 || rdata[0 +: XLEN] !== 32'h9999_0009) begin
            failures++; $display("FAIL t4_same_cycle got=%b/%0d/%h exp=1/6/99990009", rbusy[0], rtag[0 +: TAG_W], rdata[0 +: XLEN]); end
    endtask

    task automatic test_flush();
        for (int i = 1; i <= 10; i++) begin
            idle(); we = 1'b1; waddr = AW'(i); wdata = 32'hA000_0000 + i; wtag = 4'hF;
            tick();
        end
        for (int i = 1; i <= 10; i++) begin
            idle(); ren_en = 1'b1; ren_addr = AW'(i); ren_tag = TAG_W'(i);
            tick();
        end
        idle();
        checks++; if (busy_cnt !== 6'd10) begin failures++; $display("FAIL t5_pre_flush_cnt got=%0d exp=10", busy_cnt); end
        flush = 1'b1; ren_en = 1'b1; ren_addr = 5'd11; ren_tag = 4'd7;
        tick();
        idle(); rd(0, 5'd11);
        #1;
        checks++; if (busy_cnt !== 6'd0 || rbusy[0] !== 1'b0) begin
            failures++; $display("FAIL t5_flush got=%0d/%b exp=0/0", busy_cnt, rbusy[0]); end
        for (int i = 1; i <= 10; i += 2) begin
            idle(); rd(0, AW'(i)); rd(1, AW'(i + 1));
            #1;
            checks++; if (rdata[0 +: XLEN] !== 32'hA000_0000 + i || rdata[XLEN +: XLEN] !== 32'hA000_0001 + i || rbusy !== 2'b00) begin
                failures++; $display("FAIL t5_data x%0d got=%h/%h/%b exp=%h/%h/00", i, rdata[0 +: XLEN], rdata[XLEN +: XLEN], rbusy, 32'hA000_0000 + i, 32'hA000_0001 + i); end
            tick();
        end
    endtask

    task automatic test_x0();
        logic [AW:0] cnt0;
        idle(); ren_en = 1'b1; ren_addr = 5'd2; ren_tag = 4'd8;
        tick();
        cnt0 = busy_cnt;
        checks++; if (cnt0 !== 6'd1) begin failures++; $display("FAIL t6_cnt_setup got=%0d exp=1", cnt0); end
        idle(); we = 1'b1; waddr = 5'd0; wdata = 32'hFFFF_FFFF; wtag = 4'd0; rd(0, 5'd0); rd(1, 5'd0);
        #1;
        checks++; if (rdata !== '0 || rbusy !== '0 || rtag !== '0) begin
            failures++; $display("FAIL t6_x0_bypass got=%h/%b/%h exp=0/0/0", rdata, rbusy, rtag); end
        tick();
        idle(); ren_en = 1'b1; ren_addr = 5'd0; ren_tag = 4'd5;
        tick();
        idle(); rd(0, 5'd0); rd(1, 5'd0);
        #1;
        checks++; if (rdata !== '0 || rbusy !== '0 || rtag !== '0 || busy_cnt !== 6'd1) begin
            failures++; $display("FAIL t6_x0_read got=%h/%b/%h/%0d exp=0/0/0/1", rdata, rbusy, rtag, busy_cnt); end
    endtask

    task automatic test_random();
        logic [XLEN-1:0]  ed;
        logic             eb;
        logic [TAG_W-1:0] et;
        for (int c = 0; c < 400; c++) begin
            idle();
            we       = ($urandom_range(0, 2) != 0);
            waddr    = ($urandom_range(0, 3) == 0) ? AW'($urandom) : AW'($urandom_range(0, 7));
            wdata    = $urandom;
            wtag     = ($urandom_range(0, 1) == 1) ? m_tag[waddr] : TAG_W'($urandom);
            ren_en   = ($urandom_range(0, 1) == 1);
            ren_addr = AW'($urandom_range(0, 7));
            ren_tag  = TAG_W'($urandom);
            flush    = ($urandom_range(0, 15) == 0);
            re       = NRD'($urandom);
            for (int p = 0; p < NRD; p++) begin
                raddr[p*AW +: AW] = ($urandom_range(0, 1) == 1) ? waddr : AW'($urandom_range(0, 9));
            end
            #1;
            for (int p = 0; p < NRD; p++) begin
                m_read(re[p], raddr[p*AW +: AW], ed, eb, et);
                checks++; if (rdata[p*XLEN +: XLEN] !== ed) begin failures++; $display("FAIL rand_rdata c%0d p%0d got=%h exp=%h", c, p, rdata[p*XLEN +: XLEN], ed); end
                checks++; if (rbusy[p] !== eb) begin failures++; $display("FAIL rand_rbusy c%0d p%0d got=%b exp=%b", c, p, rbusy[p], eb); end
                checks++; if (rtag[p*TAG_W +: TAG_W] !== et) begin failures++; $display("FAIL rand_rtag c%0d p%0d got=%0d exp=%0d", c, p, rtag[p*TAG_W +: TAG_W], et); end
            end
            tick();
            checks++; if (int'(busy_cnt) !== m_count()) begin failures++; $display("FAIL rand_busy_cnt c%0d got=%0d exp=%0d", c, busy_cnt, m_count()); end
        end
    endtask

    initial begin
        test_reset();
        test_rename_commit();
        test_stale_commit();
        test_commit_rename_same_cycle();
        test_flush();
        test_x0();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
